// File: rtl/network_mul_pkg.sv
// network_mul_pkg: shared operand/product widths and requester-tag width helper
package network_mul_pkg;
  localparam int MUL_A_W = 16;
  localparam int MUL_B_W = 13;
  localparam int MUL_P_W = MUL_A_W + MUL_B_W;
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/network_mul_share_rr_grant.sv
// network_mul_share_rr_grant: round-robin one-hot grant starting after the last winner
module network_mul_share_rr_grant #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
)(
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_last,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [ID_W-1:0] o_idx
);
  logic            w_found;
  logic [ID_W-1:0] w_j;
  // scan requesters from last+1 with wrap, first valid one wins
  always_comb begin
    int j;
    j = 0;
    o_gnt = '0;
    o_idx = '0;
    w_found = 1'b0;
    w_j = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(i_last) + k;
      j = (j >= NREQ) ? j - NREQ : j;
      w_j = ID_W'(j);
      if (i_en && !w_found && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx = w_j;
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/network_mul_share_arb.sv
// network_mul_share_arb: round-robin shared signed multiplier with two-stage pipeline and ID tags
module network_mul_share_arb
  import network_mul_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int A_W  = MUL_A_W,
  parameter int B_W  = MUL_B_W,
  parameter int P_W  = A_W + B_W,
  parameter int ID_W = id_width(NREQ)
)(
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [P_W-1:0]      res_p,
  output logic [ID_W-1:0]     res_id,
  output logic                busy
);
  logic signed [A_W-1:0] w_a [NREQ];
  logic signed [B_W-1:0] w_b [NREQ];
  logic                  w_s2_load, w_s1_move, w_s1_load, w_acc;
  logic [NREQ-1:0]       w_gnt;
  logic [ID_W-1:0]       w_idx;
  logic                  r_s1_v, r_s2_v;
  logic signed [A_W-1:0] r_s1_a;
  logic signed [B_W-1:0] r_s1_b;
  logic [ID_W-1:0]       r_s1_id, r_s2_id, r_rr_last;
  logic signed [P_W-1:0] r_s2_p;
  // unpack per-requester operands
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_a[i] = req_a[i*A_W +: A_W];
      w_b[i] = req_b[i*B_W +: B_W];
    end
  end
  // S2 drains or is empty; S1 may take a new pair when it is empty or moving on
  always_comb begin
    w_s2_load = !r_s2_v || res_ready;
    w_s1_move = r_s1_v && w_s2_load;
    w_s1_load = !r_s1_v || w_s1_move;
    w_acc     = |w_gnt;
  end
  // grants are masked during reset so req_ready stays low while held in reset
  network_mul_share_rr_grant #(.NREQ(NREQ), .ID_W(ID_W)) u_grant (
    .i_req  (req_valid),
    .i_last (r_rr_last),
    .i_en   (w_s1_load && ap_rst_n),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );
  // operand stage, product stage and round-robin pointer
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_id   <= '0;
      r_s2_v    <= 1'b0;
      r_s2_p    <= '0;
      r_s2_id   <= '0;
      r_rr_last <= ID_W'(NREQ - 1);
    end else begin
      if (w_acc) begin
        r_s1_v    <= 1'b1;
        r_s1_a    <= w_a[w_idx];
        r_s1_b    <= w_b[w_idx];
        r_s1_id   <= w_idx;
        r_rr_last <= w_idx;
      end else if (w_s1_move) begin
        r_s1_v <= 1'b0;
      end
      if (w_s2_load) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_p  <= P_W'(r_s1_a) * P_W'(r_s1_b);
          r_s2_id <= r_s1_id;
        end
      end
    end
  end
  assign req_ready = w_gnt;
  assign res_valid = r_s2_v;
  assign res_p     = r_s2_p;
  assign res_id    = r_s2_id;
  assign busy      = r_s1_v || r_s2_v;
endmodule
